// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I fetch stage and its queue.
package fetch_unit_pkg;

  // Canonical NOP (addi x0, x0, 0) presented when no instruction is valid
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued fetch result: the instruction word and the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a 32-bit word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO between instruction memory and decode.
// slot0 is always the head; flush wins over push.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop_s;

  // Next-state for the two slots and the occupancy count
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    count_d  = count_q;
    do_pop_s = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, do_pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = push_data_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_d = push_data_i;
            count_d = 2'd2;
          end else begin
            // full: the issue logic never lets this happen, keep contents
            count_d = count_q;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_data_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Queue storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= fetch_entry_t'(64'h0);
      slot1_q <= fetch_entry_t'(64'h0);
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, 1-cycle imem request tracking,
// redirect flushing and a valid/ready handoff to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;
  logic [1:0]   q_count_s;
  fetch_entry_t q_head_s;
  fetch_entry_t push_data_s;
  logic         head_valid_s;
  logic         pop_s;
  logic         push_s;
  logic [2:0]   occupancy_s;
  logic [31:0]  target_s;

  // Decode handshake, head presentation and the request issue decision
  always_comb begin
    target_s     = word_align(redirect_pc);
    head_valid_s = (q_count_s != 2'd0) && !rst;
    pop_s        = head_valid_s && inst_ready && !redirect;
    // slots that will be taken once this cycle's pop is accounted for
    occupancy_s  = {1'b0, q_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    if (rst) begin
      imem_en   = 1'b0;
      imem_addr = fetch_pc_q;
    end else if (redirect) begin
      imem_en   = 1'b1;
      imem_addr = target_s;
    end else begin
      imem_en   = (occupancy_s < DEPTH_L);
      imem_addr = fetch_pc_q;
    end
    inst_valid = head_valid_s;
    if (head_valid_s) begin
      inst = q_head_s.inst;
      pc   = q_head_s.pc;
    end else begin
      inst = NOP;
      pc   = 32'h0000_0000;
    end
  end

  // Next fetch PC and in-flight tracking; a redirect restarts at its target
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect) begin
      inflight_d    = 1'b1;
      inflight_pc_d = target_s;
      fetch_pc_d    = target_s + 32'd4;
    end else if (imem_en) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end else begin
      inflight_d    = 1'b0;
    end
  end

  // PC and in-flight registers; reset drops any outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= word_align(RESET_PC);
      inflight_pc_q <= 32'h0000_0000;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  // A response is only kept when no redirect is killing it this cycle
  assign push_s      = inflight_q && !redirect;
  assign push_data_s = '{pc: inflight_pc_q, inst: imem_rdata};

  fetch_queue u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .count_o     (q_count_s),
    .head_o      (q_head_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  // model: queued {pc, inst}, outstanding request, next sequential address
  logic [63:0] mq[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_ipc  = 32'h0;
  logic [31:0] m_fpc  = 32'h0;

  logic        obs_en;
  logic [31:0] obs_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    bit          e_valid, e_pop, e_en;
    int          occ;
    logic [31:0] e_inst, e_pc, e_addr;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
    #1;
    e_valid = !r && (mq.size() > 0);
    e_inst  = e_valid ? mq[0][31:0]  : NOP;
    e_pc    = e_valid ? mq[0][63:32] : 32'h0;
    e_pop   = e_valid && rdy && !rd;
    occ     = mq.size() + int'(m_infl) - int'(e_pop);
    e_en    = r ? 1'b0 : (rd ? 1'b1 : (occ < 2));
    e_addr  = rd ? {rpc[31:2], 2'b00} : m_fpc;
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    check_eq("inst", inst, e_inst);
    check_eq("pc", pc, e_pc);
    check_eq("imem_en", {31'b0, imem_en}, {31'b0, e_en});
    if (e_en) check_eq("imem_addr", imem_addr, e_addr);
    obs_en   = imem_en;
    obs_addr = imem_addr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = 32'h0;
    end else if (rd) begin
      mq.delete();
      m_infl = 1'b1;
      m_ipc  = e_addr;
      m_fpc  = e_addr + 32'd4;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back({m_ipc, imem_rdata});
      m_infl = e_en;
      if (e_en) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
    imem_rdata = e_en ? (e_addr ^ K) : $urandom;
  endtask

  initial begin
    // reset held, then release with decode always ready
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("first_fetch_en", {31'b0, obs_en}, 32'd1);
    check_eq("first_fetch_addr", obs_addr, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // backpressure then release
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("stall_no_fetch", {31'b0, obs_en}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // full queue plus in-flight, then redirect
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    check_eq("redir_addr", obs_addr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // redirect together with ready, then back-to-back redirects
    step(1'b0, 1'b1, 32'h0000_0180, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // misaligned target and address wrap
    step(1'b0, 1'b1, 32'h0000_0043, 1'b1);
    check_eq("align_addr", obs_addr, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_addr", obs_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // reset mid-stream with the queue full
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("rst_en", {31'b0, obs_en}, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic        r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      rd  = ($urandom_range(7) == 0);
      rdy = ($urandom_range(9) < 7);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
      step(r, rd, rpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
